// File: rtl/rob_module.sv
// Reorder buffer: allocates entries in program order, resolves dispatched operands
// against completed entries, captures FU results and retires the oldest entry in order.

package rob_pkg;
    typedef logic [3:0] nzcv_t;
endpackage

module rob_module
    import rob_pkg::*;
#(
    parameter int ROB_IDX_SIZE = 4,
    parameter int ROB_DEPTH    = 2 ** ROB_IDX_SIZE,
    parameter int GPR_IDX_SIZE = 5,
    parameter int GPR_SIZE     = 32
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic                    in_rf_ready,
    input  logic [GPR_IDX_SIZE-1:0] in_rf_dst,
    input  logic                    in_rf_set_nzcv,
    input  logic                    in_rf_src1_valid,
    input  logic                    in_rf_src2_valid,
    input  logic                    in_rf_nzcv_valid,
    input  logic [GPR_SIZE-1:0]     in_rf_src1_value,
    input  logic [GPR_SIZE-1:0]     in_rf_src2_value,
    input  nzcv_t                   in_rf_nzcv,
    input  logic [ROB_IDX_SIZE-1:0] in_rf_src1_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_rf_src2_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_rf_nzcv_rob_index,
    input  logic                    in_fu_done,
    input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
    input  logic [GPR_SIZE-1:0]     in_fu_value,
    input  nzcv_t                   in_fu_nzcv,
    output logic                    out_rf_full,
    output logic                    out_rs_valid,
    output logic [ROB_IDX_SIZE-1:0] out_rs_rob_index,
    output logic                    out_rs_src1_valid,
    output logic                    out_rs_src2_valid,
    output logic                    out_rs_nzcv_valid,
    output logic [GPR_SIZE-1:0]     out_rs_src1_value,
    output logic [GPR_SIZE-1:0]     out_rs_src2_value,
    output nzcv_t                   out_rs_nzcv,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
    output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
    output logic [ROB_IDX_SIZE-1:0] out_rs_nzcv_rob_index,
    output logic                    out_rf_should_commit,
    output logic [ROB_IDX_SIZE-1:0] out_rf_commit_rob_index,
    output logic [GPR_IDX_SIZE-1:0] out_rf_reg_index,
    output logic [GPR_SIZE-1:0]     out_rf_commit_value,
    output logic                    out_rf_set_nzcv,
    output nzcv_t                   out_rf_nzcv
);
    localparam logic [ROB_IDX_SIZE:0] DEPTH_C = (ROB_IDX_SIZE + 1)'(ROB_DEPTH);

    logic [ROB_DEPTH-1:0]    valid_q;
    logic [ROB_DEPTH-1:0]    done_q;
    logic [ROB_DEPTH-1:0]    set_nzcv_q;
    logic [GPR_IDX_SIZE-1:0] dst_q   [ROB_DEPTH];
    logic [GPR_SIZE-1:0]     value_q [ROB_DEPTH];
    nzcv_t                   nzcv_q  [ROB_DEPTH];
    logic [ROB_IDX_SIZE-1:0] head_q, tail_q;
    logic [ROB_IDX_SIZE:0]   count_q;

    logic            commit, alloc, wb;
    logic [GPR_SIZE:0] src1_res, src2_res;
    logic [4:0]      nzcv_res;

    // A retiring head frees its slot on the same edge, so a full buffer can still accept.
    assign commit      = valid_q[head_q] && done_q[head_q];
    assign out_rf_full = (count_q == DEPTH_C) && !commit;
    assign alloc       = in_rf_ready && !out_rf_full;
    assign wb          = in_fu_done && valid_q[in_fu_rob_index];

    function automatic logic [GPR_SIZE:0] resolve_gpr(
        input logic rf_valid, input logic [GPR_SIZE-1:0] rf_value,
        input logic stored_ok, input logic [GPR_SIZE-1:0] stored,
        input logic bypass_ok, input logic [GPR_SIZE-1:0] bypass);
        if (rf_valid)  return {1'b1, rf_value};
        if (stored_ok) return {1'b1, stored};
        if (bypass_ok) return {1'b1, bypass};
        return {1'b0, rf_value};
    endfunction

    function automatic logic [4:0] resolve_nzcv(
        input logic rf_valid, input nzcv_t rf_value,
        input logic stored_ok, input nzcv_t stored,
        input logic bypass_ok, input nzcv_t bypass);
        if (rf_valid)  return {1'b1, rf_value};
        if (stored_ok) return {1'b1, stored};
        if (bypass_ok) return {1'b1, bypass};
        return {1'b0, rf_value};
    endfunction

    assign src1_res = resolve_gpr(in_rf_src1_valid, in_rf_src1_value,
        valid_q[in_rf_src1_rob_index] && done_q[in_rf_src1_rob_index], value_q[in_rf_src1_rob_index],
        in_fu_done && (in_fu_rob_index == in_rf_src1_rob_index), in_fu_value);
    assign src2_res = resolve_gpr(in_rf_src2_valid, in_rf_src2_value,
        valid_q[in_rf_src2_rob_index] && done_q[in_rf_src2_rob_index], value_q[in_rf_src2_rob_index],
        in_fu_done && (in_fu_rob_index == in_rf_src2_rob_index), in_fu_value);
    assign nzcv_res = resolve_nzcv(in_rf_nzcv_valid, in_rf_nzcv,
        valid_q[in_rf_nzcv_rob_index] && done_q[in_rf_nzcv_rob_index], nzcv_q[in_rf_nzcv_rob_index],
        in_fu_done && (in_fu_rob_index == in_rf_nzcv_rob_index), in_fu_nzcv);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_q                 <= '0;
            done_q                  <= '0;
            head_q                  <= '0;
            tail_q                  <= '0;
            count_q                 <= '0;
            out_rs_valid            <= 1'b0;
            out_rs_rob_index        <= '0;
            out_rs_src1_valid       <= 1'b0;
            out_rs_src2_valid       <= 1'b0;
            out_rs_nzcv_valid       <= 1'b0;
            out_rs_src1_value       <= '0;
            out_rs_src2_value       <= '0;
            out_rs_nzcv             <= '0;
            out_rs_src1_rob_index   <= '0;
            out_rs_src2_rob_index   <= '0;
            out_rs_nzcv_rob_index   <= '0;
            out_rf_should_commit    <= 1'b0;
            out_rf_commit_rob_index <= '0;
            out_rf_reg_index        <= '0;
            out_rf_commit_value     <= '0;
            out_rf_set_nzcv         <= 1'b0;
            out_rf_nzcv             <= '0;
        end else begin
            // Later assignments win: allocation into a slot freed this edge overrides the clear.
            if (commit) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (wb) done_q[in_fu_rob_index] <= 1'b1;
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            case ({alloc, commit})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase

            out_rs_valid <= alloc;
            if (alloc) begin
                out_rs_rob_index      <= tail_q;
                out_rs_src1_valid     <= src1_res[GPR_SIZE];
                out_rs_src1_value     <= src1_res[GPR_SIZE-1:0];
                out_rs_src2_valid     <= src2_res[GPR_SIZE];
                out_rs_src2_value     <= src2_res[GPR_SIZE-1:0];
                out_rs_nzcv_valid     <= nzcv_res[4];
                out_rs_nzcv           <= nzcv_res[3:0];
                out_rs_src1_rob_index <= in_rf_src1_rob_index;
                out_rs_src2_rob_index <= in_rf_src2_rob_index;
                out_rs_nzcv_rob_index <= in_rf_nzcv_rob_index;
            end

            out_rf_should_commit <= commit;
            if (commit) begin
                out_rf_commit_rob_index <= head_q;
                out_rf_reg_index        <= dst_q[head_q];
                out_rf_commit_value     <= value_q[head_q];
                out_rf_set_nzcv         <= set_nzcv_q[head_q];
                out_rf_nzcv             <= nzcv_q[head_q];
            end
        end
    end

    // NOTE: payload storage has no reset; valid_q alone decides whether an entry means anything.
    always_ff @(posedge in_clk) begin
        if (wb) begin
            value_q[in_fu_rob_index] <= in_fu_value;
            nzcv_q[in_fu_rob_index]  <= in_fu_nzcv;
        end
        if (alloc) begin
            dst_q[tail_q]      <= in_rf_dst;
            set_nzcv_q[tail_q] <= in_rf_set_nzcv;
        end
    end

endmodule
